// File: rtl/seg7_display_ctrl.sv
// Six-digit 7-segment display controller: a 24-bit write is shown as hex directly or as
// decimal via a 20-cycle double-dabble conversion; patterns are held until the next write.
module seg7_display_ctrl #(
    parameter bit BLANK_LZ       = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wr_valid,
    output logic        o_wr_ready,
    input  logic [23:0] i_wr_data,
    input  logic        i_wr_hex,
    output logic        o_busy,
    output logic [6:0]  o_seg7_0,
    output logic [6:0]  o_seg7_1,
    output logic [6:0]  o_seg7_2,
    output logic [6:0]  o_seg7_3,
    output logic [6:0]  o_seg7_4,
    output logic [6:0]  o_seg7_5
);
    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    state_t      r_state, w_next;
    logic [23:0] r_bcd;
    logic [19:0] r_bin;
    logic        r_ovf;
    logic [4:0]  r_cnt;
    logic [6:0]  r_seg [6];

    logic        w_xfer;
    logic        w_ovf;
    logic [23:0] w_adj;
    logic [5:0]  w_lz;
    logic [6:0]  w_seg [6];

    function automatic logic [6:0] f_enc(input logic [3:0] d);
        case (d)
            4'h0: f_enc = 7'b1000000;
            4'h1: f_enc = 7'b1111001;
            4'h2: f_enc = 7'b0100100;
            4'h3: f_enc = 7'b0110000;
            4'h4: f_enc = 7'b0011001;
            4'h5: f_enc = 7'b0010010;
            4'h6: f_enc = 7'b0000010;
            4'h7: f_enc = 7'b1111000;
            4'h8: f_enc = 7'b0000000;
            4'h9: f_enc = 7'b0010000;
            4'hA: f_enc = 7'b0001000;
            4'hB: f_enc = 7'b0000011;
            4'hC: f_enc = 7'b1000110;
            4'hD: f_enc = 7'b0100001;
            4'hE: f_enc = 7'b0000110;
            default: f_enc = 7'b0001110;
        endcase
    endfunction

    // Ready/busy are forced low while reset is held, independent of the state register.
    assign o_wr_ready = (r_state == IDLE) && !i_reset;
    assign o_busy     = (r_state != IDLE) && !i_reset;
    assign w_xfer     = i_wr_valid && o_wr_ready;
    assign w_ovf      = (i_wr_data[23:20] != 4'd0) || (i_wr_data > 24'd999999);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_xfer) w_next = (i_wr_hex || w_ovf) ? LOAD : CONV;
            CONV: if (r_cnt == 5'd19) w_next = LOAD;
            LOAD: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_adj = r_bcd;
        for (int k = 0; k < 6; k++)
            if (r_bcd[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end

    // Digit k is a leading zero when it and every digit above it are zero.
    always_comb begin
        w_lz = '0;
        for (int k = 0; k < 6; k++) begin
            w_lz[k]  = ((r_bcd >> (4 * k)) == 24'd0);
            w_seg[k] = f_enc(r_bcd[4*k +: 4]);
            if (r_ovf)
                w_seg[k] = SEG_DASH;
            else if (BLANK_LZ && (k != 0) && w_lz[k])
                w_seg[k] = SEG_BLANK;
            if (!SEG_ACTIVE_LOW) w_seg[k] = ~w_seg[k];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_bcd   <= '0;
            r_bin   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
            for (int k = 0; k < 6; k++)
                r_seg[k] <= SEG_ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: if (w_xfer) begin
                    // Hex digits go straight into the digit register; decimal starts from zero.
                    r_bcd <= i_wr_hex ? i_wr_data : 24'd0;
                    r_bin <= i_wr_data[19:0];
                    r_ovf <= !i_wr_hex && w_ovf;
                    r_cnt <= '0;
                end
                CONV: begin
                    {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
                    r_cnt          <= r_cnt + 5'd1;
                end
                LOAD: for (int k = 0; k < 6; k++) r_seg[k] <= w_seg[k];
                default: ;
            endcase
        end
    end

    assign o_seg7_0 = r_seg[0];
    assign o_seg7_1 = r_seg[1];
    assign o_seg7_2 = r_seg[2];
    assign o_seg7_3 = r_seg[3];
    assign o_seg7_4 = r_seg[4];
    assign o_seg7_5 = r_seg[5];
endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Scoreboard bench for seg7_display_ctrl: a default instance and an inverted-polarity,
// no-blanking instance share stimulus; accepted writes push expected patterns to a queue.
module tb_seg7_display_ctrl;
    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_wr_valid = 1'b0;
    logic [23:0] i_wr_data = '0;
    logic        i_wr_hex = 1'b0;
    logic        o_wr_ready, o_busy, r2_ready, r2_busy;
    logic [6:0]  a0, a1, a2, a3, a4, a5;
    logic [6:0]  b0, b1, b2, b3, b4, b5;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [41:0] e1;
        logic [41:0] e2;
    } exp_t;
    exp_t q[$];

    logic [6:0] ENC [16];

    always #5 i_clk = ~i_clk;

    seg7_display_ctrl #(.BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
        .i_wr_data(i_wr_data), .i_wr_hex(i_wr_hex), .o_busy(o_busy),
        .o_seg7_0(a0), .o_seg7_1(a1), .o_seg7_2(a2), .o_seg7_3(a3), .o_seg7_4(a4), .o_seg7_5(a5));

    seg7_display_ctrl #(.BLANK_LZ(1'b0), .SEG_ACTIVE_LOW(1'b0)) dut2 (
        .i_clk(i_clk), .i_reset(i_reset), .i_wr_valid(i_wr_valid), .o_wr_ready(r2_ready),
        .i_wr_data(i_wr_data), .i_wr_hex(i_wr_hex), .o_busy(r2_busy),
        .o_seg7_0(b0), .o_seg7_1(b1), .o_seg7_2(b2), .o_seg7_3(b3), .o_seg7_4(b4), .o_seg7_5(b5));

    function automatic logic [41:0] segs1();
        return {a5, a4, a3, a2, a1, a0};
    endfunction

    function automatic logic [41:0] segs2();
        return {b5, b4, b3, b2, b1, b0};
    endfunction

    function automatic logic [41:0] model(input logic [23:0] d, input bit hex, input bit blz, input bit al);
        logic [3:0]  dig [6];
        logic [6:0]  s;
        logic [41:0] r;
        int          v, top;
        bit          ovf;
        ovf = !hex && (d > 24'd999999);
        v = int'(d);
        for (int k = 0; k < 6; k++) begin
            if (hex) dig[k] = d[4*k +: 4];
            else begin dig[k] = 4'(v % 10); v = v / 10; end
        end
        top = 0;
        for (int k = 0; k < 6; k++) if (dig[k] != 4'd0) top = k;
        r = '0;
        for (int k = 0; k < 6; k++) begin
            if (ovf) s = 7'b0111111;
            else if (blz && k > top) s = 7'b1111111;
            else s = ENC[dig[k]];
            if (!al) s = ~s;
            r[7*k +: 7] = s;
        end
        return r;
    endfunction

    always @(posedge i_clk)
        if (!i_reset && i_wr_valid && o_wr_ready)
            q.push_back('{e1: model(i_wr_data, i_wr_hex, 1'b1, 1'b1),
                          e2: model(i_wr_data, i_wr_hex, 1'b0, 1'b0)});

    task automatic write(input logic [23:0] d, input logic h);
        i_wr_data = d; i_wr_hex = h; i_wr_valid = 1'b1;
        @(negedge i_clk);
        i_wr_valid = 1'b0;
    endtask

    // Waits for ready, checks outputs never moved meanwhile, latency, and scoreboard head.
    task automatic wait_done(input string nm, input int exp_lat, input int pulse_at);
        logic [41:0] p1, p2;
        int cnt;
        exp_t e;
        p1 = segs1(); p2 = segs2(); cnt = 0;
        while (!o_wr_ready && cnt < 60) begin
            total++;
            if (segs1() !== p1 || segs2() !== p2) begin
                bad++;
                $display("FAIL %s_stable cyc=%0d got=%h/%h want=%h/%h", nm, cnt, segs1(), segs2(), p1, p2);
            end
            cnt++;
            if (cnt == pulse_at) begin i_wr_valid = 1'b1; i_wr_data = 24'h777777; i_wr_hex = 1'b1; end
            if (cnt == pulse_at + 2) i_wr_valid = 1'b0;
            @(negedge i_clk);
        end
        total++;
        if (cnt !== exp_lat) begin
            bad++; $display("FAIL %s_latency got=%0d want=%0d", nm, cnt, exp_lat);
        end
        total++;
        if (q.size() == 0) begin
            bad++; $display("FAIL %s_scoreboard got=empty want=entry", nm);
        end else begin
            e = q.pop_front();
            if (segs1() !== e.e1 || segs2() !== e.e2) begin
                bad++;
                $display("FAIL %s_segs got=%h/%h want=%h/%h", nm, segs1(), segs2(), e.e1, e.e2);
            end
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_wr_valid = 1'b0;
        @(negedge i_clk); @(negedge i_clk);
        total++;
        if (segs1() !== {42{1'b1}} || segs2() !== 42'd0) begin
            bad++; $display("FAIL reset_segs got=%h/%h want=all1/all0", segs1(), segs2());
        end
        total++;
        if (o_wr_ready !== 1'b0 || o_busy !== 1'b0) begin
            bad++; $display("FAIL reset_hs got=%b%b want=00", o_wr_ready, o_busy);
        end
        i_reset = 1'b0;
        @(negedge i_clk);
        total++;
        if (o_wr_ready !== 1'b1 || o_busy !== 1'b0 || r2_ready !== 1'b1) begin
            bad++; $display("FAIL reset_release got=%b%b%b want=101", o_wr_ready, o_busy, r2_ready);
        end
    endtask

    task automatic test_hex();
        write(24'h00ABCD, 1'b1); wait_done("hex_abcd", 1, -1);
        write(24'h123456, 1'b1); wait_done("hex_full", 1, -1);
        write(24'hF00E00, 1'b1); wait_done("hex_inner0", 1, -1);
    endtask

    task automatic test_decimal();
        write(24'h01E240, 1'b0); wait_done("dec_123456", 21, -1);
        write(24'd0, 1'b0);      wait_done("dec_zero", 21, -1);
        write(24'd999999, 1'b0); wait_done("dec_max", 21, -1);
        write(24'd1000000, 1'b0); wait_done("dec_ovf_1m", 1, -1);
        write(24'h100000, 1'b0); wait_done("dec_ovf_hi", 1, -1);
        write(24'd905, 1'b0);    wait_done("dec_905", 21, -1);
    endtask

    task automatic test_reset_mid();
        write(24'd999999, 1'b0);
        repeat (9) @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
        total++;
        if (segs1() !== {42{1'b1}} || segs2() !== 42'd0 || o_wr_ready !== 1'b0 || o_busy !== 1'b0) begin
            bad++; $display("FAIL midreset got=%h/%h rdy=%b busy=%b", segs1(), segs2(), o_wr_ready, o_busy);
        end
        i_reset = 1'b0;
        q.delete();
        @(negedge i_clk);
        total++;
        if (o_wr_ready !== 1'b1) begin
            bad++; $display("FAIL midreset_ready got=%b want=1", o_wr_ready);
        end
        write(24'h000001, 1'b1); wait_done("midreset_hex1", 1, -1);
    endtask

    task automatic test_back_to_back();
        logic [23:0] vals [4];
        logic        hexs [4];
        int          lats [4];
        vals = '{24'h00000F, 24'd42, 24'hABCDEF, 24'd7};
        hexs = '{1'b1, 1'b0, 1'b1, 1'b0};
        lats = '{1, 21, 1, 21};
        for (int i = 0; i < 4; i++) begin
            i_wr_data = vals[i]; i_wr_hex = hexs[i]; i_wr_valid = 1'b1;
            @(negedge i_clk);
            wait_done("b2b", lats[i], -1);
        end
        i_wr_valid = 1'b0;
        @(negedge i_clk);
        total++;
        if (q.size() != 0) begin
            bad++; $display("FAIL b2b_extra got=%0d want=0", q.size());
        end
    endtask

    task automatic test_busy_drop();
        write(24'd314159, 1'b0); wait_done("drop_dec", 21, 3);
        write(24'h0000C0, 1'b1); wait_done("drop_hex", 1, -1);
        @(negedge i_clk);
        total++;
        if (q.size() != 0 || o_wr_ready !== 1'b1) begin
            bad++; $display("FAIL drop_extra got=%0d/%b want=0/1", q.size(), o_wr_ready);
        end
    endtask

    initial begin
        ENC = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
                7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        test_reset();
        test_hex();
        test_decimal();
        test_reset_mid();
        test_back_to_back();
        test_busy_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seg7_display_ctrl.md
Name: seg7_display_ctrl

Overview:
- Downstream output stage of the cpu: converts a value written by the core into six 7-segment digit patterns on seg7_0..seg7_5 (seg7_0 = rightmost digit).
- Decimal mode uses multi-cycle double-dabble binary-to-BCD conversion; hex mode is direct.
- Segment patterns are held until the next accepted write.
- Write port uses a valid/ready handshake so the core can stall on busy.

Parameters:
- BLANK_LZ, 1, 1 = blank leading zero digits (digit 0 is never blanked); 0 = show all six digits.
- SEG_ACTIVE_LOW, 1, 1 = segment lit when bit is 0; 0 = all segment outputs inverted.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_valid  input  1  write request.
- wr_ready  output  1  block can accept a write.
- wr_data  input  24  value to display.
- wr_hex  input  1  sampled with wr_data; 1 = hex, 0 = decimal.
- busy  output  1  conversion/load in progress; equals ~wr_ready outside reset.
- seg7_0..seg7_5  output  7 each  digit patterns; bit0 = a … bit6 = g.

Behaviour:
- Reset
  - Sampled on clk edge; while asserted: state IDLE, all seg7_* = blank (7'b1111111 when active-low), wr_ready = 0, busy = 0.
  - wr_ready = 1 from the first cycle after reset deasserts.
- Transfer and state machine
  - A transfer occurs on an edge where wr_valid & wr_ready; wr_data and wr_hex are latched at that edge.
  - Writes while wr_ready = 0 are ignored; there is no queueing.
  - States: IDLE, CONV, LOAD.
  - IDLE: wr_ready = 1. On transfer, go to LOAD if hex mode or decimal overflow; otherwise go to CONV.
  - CONV: 20 iterations, one per cycle.
    - Each iteration: add 3 to every BCD nibble ≥ 5, then shift {bcd[23:0], bin[19:0]} left by 1.
    - After the 20th iteration, go to LOAD.
  - LOAD: register the six segment patterns, then return to IDLE.
- Latency (transfer at edge N)
  - Hex/overflow: outputs update at edge N+1; wr_ready high after N+1.
  - Decimal: CONV occupies edges N+1..N+20; outputs update at N+21; wr_ready high after N+21.
  - wr_valid held high gives back-to-back writes with one IDLE cycle between them.
- Hex mode: digit k = wr_data[4k+3:4k], k = 0..5.
- Decimal mode
  - Operand is wr_data[19:0].
  - Overflow when wr_data[23:20] ≠ 0 or wr_data > 999999. On overflow all six digits show dash (g only: 7'b0111111), with no leading-zero blanking.
- Encoding (active-low, g..a)
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - blank=1111111
- Leading-zero blanking (BLANK_LZ = 1): digits above the most significant nonzero digit are blank. Value 0 shows "0" on seg7_0 only.
- Output stability: outputs change only in LOAD or on reset, and never show intermediate conversion values.
- Reset mid-operation: reset during CONV or LOAD aborts the operation. Outputs are blanked and the pending value is discarded.

Test Plan:
- Reset held 2 cycles → all seg7_* = 1111111, wr_ready = 0 during reset and 1 on the following cycle.
- Hex write 24'h00ABCD → after 1 edge: seg7_3..0 = A,b,C,d patterns, seg7_5/4 blank; with BLANK_LZ = 0, seg7_5/4 = "0".
- Decimal write 123456 (24'h01E240) → wr_ready low for 21 cycles; seg7_5..0 = 1,2,3,4,5,6 at edge N+21; no intermediate output changes.
- Decimal writes 1000000 and 24'h100000 → dashes on all digits after 1 edge. Decimal write 0 → seg7_0 = 1000000, all others blank.
- Reset asserted at CONV cycle 10 of a decimal write 999999 → outputs blank; a subsequent hex write of 24'h000001 displays "1" with normal latency.
- wr_valid held high with alternating values, plus wr_valid pulsed while busy → exactly one transfer per IDLE cycle; pulses during busy are dropped and the display reflects only accepted writes.
